// File: rtl/board_io_ctrl.sv
// board_io_ctrl: CPU-bus board I/O slave.
//   - 2-FF synchronisers on the raw push buttons and switches
//   - per-key debouncer with sticky press-event capture (write-1-to-clear)
//   - hex digit value and blanking registers with registered 7-segment decode
//   - green/red LED registers and a per-key interrupt enable
//
// Bus protocol: io_rd / io_wr are single-cycle strobes with no back-pressure
// (the slave is always ready). A write lands on the clock edge where io_wr
// is high. io_dout is loaded on the edge where io_rd is high and is valid
// from the following cycle. It then holds its value until the next selected
// read. If io_rd and io_wr are both high, the read returns pre-write data.
module board_io_ctrl #(
  parameter int          NUM_KEYS        = 4,
  parameter int          NUM_SW          = 10,
  parameter int          NUM_HEX         = 4,
  parameter int          NUM_LEDG        = 8,
  parameter int          NUM_LEDR        = 10,
  parameter int          DEBOUNCE_CYCLES = 240000,
  parameter logic [15:0] ADDR_BASE       = 16'h0000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_KEYS-1:0]    key,
  input  logic [NUM_SW-1:0]      sw,
  input  logic                   io_rd,
  input  logic                   io_wr,
  input  logic [15:0]            io_addr,
  input  logic [15:0]            io_din,
  output logic [15:0]            io_dout,
  output logic [7*NUM_HEX-1:0]   hex,
  output logic [NUM_LEDG-1:0]    ledg,
  output logic [NUM_LEDR-1:0]    ledr,
  output logic                   irq
);

  localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [2:0] REG_KEY_STATE = 3'd0;
  localparam logic [2:0] REG_KEY_EDGE  = 3'd1;
  localparam logic [2:0] REG_SW        = 3'd2;
  localparam logic [2:0] REG_HEX_VAL   = 3'd3;
  localparam logic [2:0] REG_BLANK     = 3'd4;
  localparam logic [2:0] REG_LEDG      = 3'd5;
  localparam logic [2:0] REG_LEDR      = 3'd6;
  localparam logic [2:0] REG_IRQ_EN    = 3'd7;

  // Active-low 7-segment pattern, bit order g..a.
  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // ---------------------------------------------------------------------------
  // Synchronisers
  // ---------------------------------------------------------------------------
  logic [NUM_KEYS-1:0] key_s1, key_s2;
  logic [NUM_SW-1:0]   sw_s1, sw_s2;
  logic [NUM_KEYS-1:0] key_sync;  // 1 = pressed

  // Two-flop synchronisers; raw keys idle high, so they reset to "released".
  always_ff @(posedge clk) begin
    if (reset) begin
      key_s1 <= '1;
      key_s2 <= '1;
      sw_s1  <= '0;
      sw_s2  <= '0;
    end else begin
      key_s1 <= key;
      key_s2 <= key_s1;
      sw_s1  <= sw;
      sw_s2  <= sw_s1;
    end
  end

  assign key_sync = ~key_s2;

  // ---------------------------------------------------------------------------
  // Debounce
  // ---------------------------------------------------------------------------
  logic [CW-1:0]       db_cnt [NUM_KEYS];
  logic [NUM_KEYS-1:0] key_db;     // debounced, 1 = pressed
  logic [NUM_KEYS-1:0] db_flip;    // debounced bit toggles this edge
  logic [NUM_KEYS-1:0] key_press;  // debounced released->pressed this edge

  // A key flips when the synced level has disagreed with the debounced level
  // for DEBOUNCE_CYCLES consecutive edges (the counter would reach the limit).
  always_comb begin
    db_flip = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      db_flip[i] = (key_sync[i] != key_db[i]) && (db_cnt[i] == CNT_LAST);
    end
  end

  assign key_press = db_flip & ~key_db;

  // Per-key stability counters and debounced state.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_db <= '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      key_db <= key_db ^ db_flip;
      for (int i = 0; i < NUM_KEYS; i++) begin
        if ((key_sync[i] == key_db[i]) || db_flip[i]) begin
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CW'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic       sel;
  logic [2:0] idx;
  logic       wr_en;
  logic       rd_en;

  assign sel   = (io_addr[15:3] == ADDR_BASE[15:3]);
  assign idx   = io_addr[2:0];
  assign wr_en = io_wr & sel;
  assign rd_en = io_rd & sel;

  // Only the low bits of the write data reach the registers.
  logic unused_din;
  assign unused_din = ^io_din;

  // ---------------------------------------------------------------------------
  // Sticky press events
  // ---------------------------------------------------------------------------
  logic [NUM_KEYS-1:0] key_edge;
  logic [NUM_KEYS-1:0] edge_clr;

  assign edge_clr = (wr_en && (idx == REG_KEY_EDGE)) ? io_din[NUM_KEYS-1:0] : '0;

  // Clear-by-write first, then OR in new presses, so a same-edge press wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_edge <= '0;
    end else begin
      key_edge <= (key_edge & ~edge_clr) | key_press;
    end
  end

  // ---------------------------------------------------------------------------
  // Read/write registers
  // ---------------------------------------------------------------------------
  logic [4*NUM_HEX-1:0] hex_val;
  logic [NUM_HEX-1:0]   blank;
  logic [NUM_KEYS-1:0]  irq_en;

  // CPU-writable registers; writes to read-only or unselected slots drop.
  always_ff @(posedge clk) begin
    if (reset) begin
      hex_val <= '0;
      blank   <= '1;
      ledg    <= '0;
      ledr    <= '0;
      irq_en  <= '0;
    end else if (wr_en) begin
      case (idx)
        REG_HEX_VAL: hex_val <= io_din[4*NUM_HEX-1:0];
        REG_BLANK:   blank   <= io_din[NUM_HEX-1:0];
        REG_LEDG:    ledg    <= io_din[NUM_LEDG-1:0];
        REG_LEDR:    ledr    <= io_din[NUM_LEDR-1:0];
        REG_IRQ_EN:  irq_en  <= io_din[NUM_KEYS-1:0];
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  logic [15:0] rd_data;

  // Zero-extended read mux over the 8-register window.
  always_comb begin
    rd_data = '0;
    case (idx)
      REG_KEY_STATE: rd_data[NUM_KEYS-1:0]  = key_db;
      REG_KEY_EDGE:  rd_data[NUM_KEYS-1:0]  = key_edge;
      REG_SW:        rd_data[NUM_SW-1:0]    = sw_s2;
      REG_HEX_VAL:   rd_data[4*NUM_HEX-1:0] = hex_val;
      REG_BLANK:     rd_data[NUM_HEX-1:0]   = blank;
      REG_LEDG:      rd_data[NUM_LEDG-1:0]  = ledg;
      REG_LEDR:      rd_data[NUM_LEDR-1:0]  = ledr;
      default:       rd_data[NUM_KEYS-1:0]  = irq_en;
    endcase
  end

  // Read data register; holds across unselected cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      io_dout <= '0;
    end else if (rd_en) begin
      io_dout <= rd_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Display and interrupt outputs
  // ---------------------------------------------------------------------------

  // Registered segment drive; digit 0 sits in the most significant slice.
  always_ff @(posedge clk) begin
    if (reset) begin
      hex <= '1;
    end else begin
      for (int i = 0; i < NUM_HEX; i++) begin
        hex[7*(NUM_HEX-i)-1 -: 7] <= blank[i] ? 7'h7F : seg7(hex_val[4*i +: 4]);
      end
    end
  end

  // Level interrupt: any enabled pending press event.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq <= 1'b0;
    end else begin
      irq <= |(key_edge & irq_en);
    end
  end

endmodule

// File: tb/tb_board_io_ctrl.sv
// tb_board_io_ctrl: directed bench for board_io_ctrl with a short debounce.
module tb_board_io_ctrl;

  localparam int NK = 4;
  localparam int NS = 10;
  localparam int NH = 4;
  localparam int NG = 8;
  localparam int NR = 10;
  localparam int DB = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [NK-1:0]     key;
  logic [NS-1:0]     sw;
  logic              io_rd;
  logic              io_wr;
  logic [15:0]       io_addr;
  logic [15:0]       io_din;
  logic [15:0]       io_dout;
  logic [7*NH-1:0]   hex;
  logic [NG-1:0]     ledg;
  logic [NR-1:0]     ledr;
  logic              irq;

  board_io_ctrl #(
    .NUM_KEYS(NK), .NUM_SW(NS), .NUM_HEX(NH), .NUM_LEDG(NG), .NUM_LEDR(NR),
    .DEBOUNCE_CYCLES(DB), .ADDR_BASE(16'h0000)
  ) dut (
    .clk(clk), .reset(reset), .key(key), .sw(sw),
    .io_rd(io_rd), .io_wr(io_wr), .io_addr(io_addr), .io_din(io_din),
    .io_dout(io_dout), .hex(hex), .ledg(ledg), .ledr(ledr), .irq(irq)
  );

  // Clock
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  typedef struct packed {
    logic        wr;
    logic [15:0] wa;
    logic [15:0] wd;
    logic [15:0] ra;
    logic [15:0] exp;
  } vec_t;

  vec_t       vt [12];
  logic [6:0] seg_tab [16];

  // All tasks start and end on a falling edge; inputs change there.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic bus_wr(input logic [15:0] a, input logic [15:0] d);
    io_wr = 1'b1; io_addr = a; io_din = d;
    tick(1);
    io_wr = 1'b0;
  endtask

  task automatic bus_rd(input logic [15:0] a, output logic [15:0] d);
    io_rd = 1'b1; io_addr = a;
    tick(1);
    io_rd = 1'b0;
    d = io_dout;
  endtask

  task automatic rd_check(input string name, input logic [15:0] a, input logic [15:0] exp);
    logic [15:0] d;
    bus_rd(a, d);
    check(name, {16'h0, d}, {16'h0, exp});
  endtask

  // Safety net so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d;
    logic [3:0]  dv;

    vt[0]  = '{1'b1, 16'h0005, 16'hFFFF, 16'h0005, 16'h00FF};
    vt[1]  = '{1'b1, 16'h0006, 16'hFFFF, 16'h0006, 16'h03FF};
    vt[2]  = '{1'b1, 16'h0006, 16'h0155, 16'h0006, 16'h0155};
    vt[3]  = '{1'b1, 16'h0002, 16'h1234, 16'h0002, 16'h02A5};
    vt[4]  = '{1'b1, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000};
    vt[5]  = '{1'b1, 16'h0007, 16'hFFFF, 16'h0007, 16'h000F};
    vt[6]  = '{1'b1, 16'h0007, 16'h0000, 16'h0007, 16'h0000};
    vt[7]  = '{1'b1, 16'h0003, 16'hABCD, 16'h0003, 16'hABCD};
    vt[8]  = '{1'b1, 16'h0004, 16'hFFFF, 16'h0004, 16'h000F};
    vt[9]  = '{1'b1, 16'h000D, 16'h0000, 16'h0005, 16'h00FF};
    vt[10] = '{1'b1, 16'h8005, 16'h0000, 16'h0005, 16'h00FF};
    vt[11] = '{1'b1, 16'h0001, 16'hFFFF, 16'h0001, 16'h0000};

    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reset block
    reset = 1'b1; key = '1; sw = 10'h2A5;
    io_rd = 1'b0; io_wr = 1'b0; io_addr = '0; io_din = '0;
    tick(3);
    check("rst_hex",  {4'h0, hex}, 32'h0FFFFFFF);
    check("rst_ledg", {24'h0, ledg}, 32'h0);
    check("rst_ledr", {22'h0, ledr}, 32'h0);
    check("rst_irq",  {31'h0, irq}, 32'h0);
    check("rst_dout", {16'h0, io_dout}, 32'h0);
    reset = 1'b0;
    tick(1);
    rd_check("rst_key_state", 16'h0000, 16'h0000);
    rd_check("rst_blank",     16'h0004, 16'h000F);

    // Register table
    for (int i = 0; i < 12; i++) begin
      exp_q.push_back({16'h0, vt[i].exp});
      if (vt[i].wr) bus_wr(vt[i].wa, vt[i].wd);
      bus_rd(vt[i].ra, d);
      check($sformatf("vec%0d", i), {16'h0, d}, exp_q.pop_front());
    end
    check("ledg_port", {24'h0, ledg}, 32'h000000FF);
    check("ledr_port", {22'h0, ledr}, 32'h00000155);

    // 7-segment decode of every digit value
    bus_wr(16'h0004, 16'h0000);
    tick(1);
    check("hex_abcd", {4'h0, hex}, {4'h0, 7'h21, 7'h46, 7'h03, 7'h08});
    for (int i = 0; i < 16; i++) begin
      dv = 4'(i);
      bus_wr(16'h0003, {4{dv}});
      tick(1);
      check($sformatf("seg_%0h", i), {4'h0, hex}, {4'h0, {4{seg_tab[i]}}});
    end

    // Display mapping, latency and blanking
    bus_wr(16'h0003, 16'h8F10);
    check("hex_latency", {4'h0, hex}, {4'h0, {4{7'h0E}}});
    tick(1);
    check("hex_8f10", {4'h0, hex}, {4'h0, 7'h40, 7'h79, 7'h0E, 7'h00});
    bus_wr(16'h0004, 16'h0002);
    tick(1);
    check("hex_blank1", {4'h0, hex}, {4'h0, 7'h40, 7'h7F, 7'h0E, 7'h00});

    // Simultaneous read and write: read returns pre-write data
    io_rd = 1'b1; io_wr = 1'b1; io_addr = 16'h0006; io_din = 16'h00AA;
    tick(1);
    io_rd = 1'b0; io_wr = 1'b0;
    check("rw_dout_old", {16'h0, io_dout}, 32'h00000155);
    check("rw_ledr_new", {22'h0, ledr}, 32'h000000AA);
    rd_check("rw_readback", 16'h0006, 16'h00AA);

    // Glitch of DB-1 synced cycles is rejected
    key[0] = 1'b0;
    tick(DB - 1);
    key[0] = 1'b1;
    tick(DB + 10);
    rd_check("glitch_state", 16'h0000, 16'h0000);
    rd_check("glitch_edge",  16'h0001, 16'h0000);

    // Bounced press on key[2]: four bounces, then held low
    for (int i = 0; i < 4; i++) begin
      key[2] = ~key[2];
      tick(3);
    end
    key[2] = ~key[2];
    io_rd = 1'b1; io_addr = 16'h0000;
    tick(DB + 2);
    check("bounce_pre",  {16'h0, io_dout}, 32'h00000000);
    tick(1);
    check("bounce_post", {16'h0, io_dout}, 32'h00000004);
    io_rd = 1'b0;
    rd_check("bounce_edge",   16'h0001, 16'h0004);
    rd_check("edge_no_rdclr", 16'h0001, 16'h0004);

    // Release sets no event
    key[2] = 1'b1;
    tick(DB + 14);
    rd_check("release_state", 16'h0000, 16'h0000);
    rd_check("release_edge",  16'h0001, 16'h0004);

    // W1C on the same edge as a new debounced press: set wins
    key[2] = 1'b0;
    tick(DB + 1);
    bus_wr(16'h0001, 16'h0004);
    rd_check("race_edge",  16'h0001, 16'h0004);
    bus_wr(16'h0001, 16'h0004);
    rd_check("w1c_clear",  16'h0001, 16'h0000);

    // Interrupt timing
    bus_wr(16'h0007, 16'h0001);
    key[0] = 1'b0;
    tick(DB + 2);
    check("irq_pre",  {31'h0, irq}, 32'h0);
    tick(1);
    check("irq_rise", {31'h0, irq}, 32'h1);
    bus_wr(16'h0001, 16'h0001);
    check("irq_hold", {31'h0, irq}, 32'h1);
    tick(1);
    check("irq_fall", {31'h0, irq}, 32'h0);
    rd_check("both_pressed", 16'h0000, 16'h0005);
    bus_rd(16'h0009, d);
    check("unsel_rd", {16'h0, d}, 32'h00000005);

    // Reset in the middle of a debounce and a write
    key = 4'b1101;
    tick(10);
    reset = 1'b1; key = '1;
    io_wr = 1'b1; io_addr = 16'h0005; io_din = 16'h003C;
    tick(1);
    io_wr = 1'b0;
    tick(2);
    reset = 1'b0;
    check("rst2_dout", {16'h0, io_dout}, 32'h0);
    check("rst2_ledg", {24'h0, ledg}, 32'h0);
    check("rst2_ledr", {22'h0, ledr}, 32'h0);
    check("rst2_hex",  {4'h0, hex}, 32'h0FFFFFFF);
    check("rst2_irq",  {31'h0, irq}, 32'h0);
    tick(DB + 14);
    rd_check("rst2_state", 16'h0000, 16'h0000);
    rd_check("rst2_edge",  16'h0001, 16'h0000);
    rd_check("rst2_irqen", 16'h0007, 16'h0000);

    // Report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
